// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared state codes, LED patterns and seven-segment decode for board_io_ctrl
package board_io_pkg;

    typedef enum logic [3:0] {
        S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
        S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
        S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11,
        S12 = 4'd12, S13 = 4'd13, S14 = 4'd14, S15 = 4'd15
    } state_e;

    localparam logic [3:0] LED_OFF   = 4'b0000;
    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_LOAD  = 4'b0010;
    localparam logic [3:0] LED_EXEC  = 4'b0100;
    localparam logic [3:0] LED_STORE = 4'b1000;
    localparam logic [3:0] LED_DONE  = 4'b1111;
    localparam logic [3:0] LED_ERR   = 4'b1010;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Groups of controller states share one indicator pattern; unused codes flag an error.
    function automatic logic [3:0] state_to_led(input logic [3:0] code);
        logic [3:0] led;
        case (state_e'(code))
            S0:                led = LED_OFF;
            S1:                led = LED_IDLE;
            S2, S3:            led = LED_LOAD;
            S4, S5, S6:        led = LED_EXEC;
            S8, S9, S10, S12:  led = LED_STORE;
            S15:               led = LED_DONE;
            default:           led = LED_ERR;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - one-bit synchroniser, tick-based debouncer and rising-edge strobe
module io_debounce #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          prev_q, prev_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive mismatching ticks; the counter stops at the threshold, never wraps.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            if (sync2_q != stable_q) begin
                if (cnt_q >= CW'(DEBOUNCE_TICKS - 1)) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
        prev_d = stable_q;
        rise_d = stable_q & ~prev_q;
    end

    // State registers; reset clears the synchroniser so a held input re-debounces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - front-panel switches, buttons, seven-segment scan and state LEDs
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int N_SW           = 4,
    parameter int N_BTN          = 4,
    parameter int N_DIGITS       = 4,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [N_SW-1:0]       Slide_Switch,
    input  logic [N_BTN-1:0]      Button,
    input  logic [4*N_DIGITS-1:0] Result,
    input  logic [N_DIGITS-1:0]   Blank,
    input  logic [3:0]            State,
    output logic [N_SW-1:0]       User_Input0,
    output logic [N_BTN-1:0]      User_Input1,
    output logic [N_BTN-1:0]      Button_Pulse,
    output logic                  Tick,
    output logic [3:0]            LED,
    output logic [6:0]            Seg,
    output logic [N_DIGITS-1:0]   Digit_Sel
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          led_q, led_d;
    logic [N_SW-1:0]     sw_rise_unused;

    assign Tick = (tick_cnt_q == TW'(CLK_DIV - 1));

    genvar g;
    generate
        for (g = 0; g < N_SW; g++) begin : g_sw
            io_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_sw (
                .clk   (CLK),
                .rst   (Reset),
                .tick  (Tick),
                .din   (Slide_Switch[g]),
                .level (User_Input0[g]),
                .rise  (sw_rise_unused[g])
            );
        end
        for (g = 0; g < N_BTN; g++) begin : g_btn
            io_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_btn (
                .clk   (CLK),
                .rst   (Reset),
                .tick  (Tick),
                .din   (Button[g]),
                .level (User_Input1[g]),
                .rise  (Button_Pulse[g])
            );
        end
    endgenerate

    // Tick divider plus display scan; segment and digit enables load together so no mixed code shows.
    always_comb begin
        tick_cnt_d = Tick ? '0 : tick_cnt_q + TW'(1);
        idx_d      = idx_q;
        sel_d      = sel_q;
        seg_d      = seg_q;
        if (Tick) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            sel_d = ~(N_DIGITS'(1) << idx_d);
            seg_d = Blank[idx_d] ? SEG_BLANK : hex_to_seg(Result[4*idx_d +: 4]);
        end
        led_d = state_to_led(State);
    end

    // Output and scan registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            tick_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= '1;
            seg_q      <= SEG_BLANK;
            led_q      <= LED_OFF;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            led_q      <= led_d;
        end
    end

    assign Seg       = seg_q;
    assign Digit_Sel = sel_q;
    assign LED       = led_q;

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board front-panel controller between the FPGA pins and the datapath/controller. Synchronises and debounces N slide switches and N push buttons, produces one-cycle press pulses, time-multiplexes an N-digit hex seven-segment display from the 16-bit-style `Result` bus, and drives a state-indicator LED pattern. A clock-enable `Tick` replaces the derived 10 kHz clock; the whole block runs on `CLK`.

## Interface
- `CLK_DIV`, 1000: `CLK` cycles per `Tick` (10 MHz → 10 kHz); ≥2.
- `N_SW`, 4: slide switch count; ≥1.
- `N_BTN`, 4: button count; ≥1.
- `N_DIGITS`, 4: display digits; ≥1.
- `DEBOUNCE_TICKS`, 20: consecutive ticks a new level must persist; ≥1.

- `CLK` in 1: system clock; the only clock.
- `Reset` in 1: asynchronous, active-high reset.
- `Slide_Switch` in `N_SW`: raw switches, asynchronous.
- `Button` in `N_BTN`: raw buttons, active-high, asynchronous.
- `Result` in 4·`N_DIGITS`: value to display; digit i = `Result[4i+3:4i]`.
- `Blank` in `N_DIGITS`: per-digit blank, 1 = all segments off.
- `State` in 4: controller state code.
- `User_Input0` out `N_SW`: debounced switch levels.
- `User_Input1` out `N_BTN`: debounced button levels.
- `Button_Pulse` out `N_BTN`: one-cycle strobe on debounced press.
- `Tick` out 1: one-cycle strobe every `CLK_DIV` cycles.
- `LED` out 4: state pattern.
- `Seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `Digit_Sel` out `N_DIGITS`: one-hot active-low digit enable.

## Operation
- Tick counter: 0..`CLK_DIV`-1, wraps; `Tick`=1 only when counter = `CLK_DIV`-1.
- Each raw input: 2-flop synchroniser, then a debouncer holding `stable` and a tick counter. On `Tick`: synced ≠ stable → counter+1; counter reaching `DEBOUNCE_TICKS` → stable := synced, counter := 0; synced = stable → counter := 0. Counter saturates and never wraps.
- `Button_Pulse[i]`=1 for exactly one `CLK` cycle after `User_Input1[i]` goes 0→1; release generates no pulse.
- Scan index 0..`N_DIGITS`-1 advances on each `Tick`, wrapping to 0. Registered `Digit_Sel` = ~(1<<index); `Seg` = hex decode of digit[index], or 7'h7F when `Blank[index]`=1.
- LED map, registered: 0 → 0000; 1 → 0001; 2,3 → 0010; 4,5,6 → 0100; 8,9,10,12 → 1000; 15 → 1111; any other code → 1010 (error).
- Reset values: `User_Input0`/`1`=0, `Button_Pulse`=0, `Tick`=0, `LED`=0000, `Seg`=7'h7F, `Digit_Sel` = all ones; internal counters, index, synchronisers and stable levels = 0.

## Timing
- Input → debounced level: 2 `CLK` cycles synchroniser, then `DEBOUNCE_TICKS` consecutive mismatching ticks; the level updates in the cycle after the final qualifying `Tick`. A glitch shorter than `DEBOUNCE_TICKS` ticks never propagates.
- `Button_Pulse`: 1 cycle after the debounced rise; width exactly 1 cycle, even if the button is held.
- `Seg`/`Digit_Sel` change in the cycle after `Tick`, together, without an intermediate mixed code. A `Result`/`Blank` change appears when its digit is next scanned, then updates on each of its scans.
- `LED`: 1-cycle latency from `State`.
- Reset asserted mid-operation: all outputs go to reset values immediately and asynchronously. After release the tick counter restarts, with the first `Tick` at cycle `CLK_DIV`-1. A button held through reset debounces to 1 and emits exactly one pulse.

## Structure
- `board_io_pkg`: state codes S0–S15, LED pattern constants, `hex_to_seg` function with 4-bit input and active-low 7-bit output.
- Sub-module `io_debounce`: one-bit synchroniser, debouncer and rise-edge detector, parametrised by `DEBOUNCE_TICKS`. It is instantiated `N_SW`+`N_BTN` times; the edge output is unused for switches.

## Test plan
Bench parameters: `CLK_DIV`=4, `DEBOUNCE_TICKS`=3, `N_DIGITS`=4.
- Reset: assert `Reset` mid-scan → same-cycle `Seg`=1111111, `Digit_Sel`=1111, `LED`=0000, `User_Input*`=0. After release → first `Tick` at cycle 3, then every 4 cycles.
- Bounce: `Button[0]` toggles every cycle for 20 cycles, then stays 1 → `User_Input1[0]` rises after 2 sync cycles + 3 ticks from the last toggle, and exactly one 1-cycle `Button_Pulse[0]`. Then a 2-tick low glitch → no change, no pulse.
- Display: `Result`=16'h12AF, `Blank`=0 → `Digit_Sel` sequence 1110, 1101, 1011, 0111 with `Seg` = 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1), repeating. Set `Blank[3]`=1 → digit 3 shows 1111111.
- LED: `State` = 0, 1, 3, 5, 9, 15, 7 → `LED` = 0000, 0001, 0010, 0100, 1000, 1111, 1010, each one cycle later.
- Switch: `Slide_Switch`=4'b1010, held 4 ticks → `User_Input0`=1010 and no `Button_Pulse` activity.
- Reset release with `Button[1]` held → one `Button_Pulse[1]` about 3 ticks later, none afterwards.
